mag_window_stats: RTL and testbench

Windowed statistics stage placed directly downstream of the vector-magnitude unit. It accepts one 8-bit magnitude sample per strobe and keeps the following:
- a circular window of the most recent 2^WIN_LOG2 samples with a running sum;
- since-clear max, min and last sample;
- an optional hysteresis alarm on the window average.

One selected statistic is presented on a registered 8-bit output, so the block can drive the chip's output pins directly.

---
 rtl/mag_window_stats.sv | 139 +++++++++++++
 tb/tb_mag_window_stats.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mag_window_stats.sv
// mag_window_stats: windowed statistics stage behind the vector-magnitude unit.
// Keeps a circular window of 2^WIN_LOG2 samples with a running sum, plus
// since-clear last/max/min, and presents one selected statistic on a
// registered 8-bit output.
// Optional feature: define MAG_ALARM_EN to build the hysteresis alarm on the
// window average; otherwise alarm is tied low.
module mag_window_stats #(
  parameter int unsigned WIN_LOG2  = 3,
  parameter logic [7:0]  THRESH_HI = 8'd200,
  parameter logic [7:0]  THRESH_LO = 8'd150
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          mag_in,
  input  logic                mag_valid,
  input  logic                clear,
  input  logic [1:0]          sel,
  output logic [7:0]          stat_out,
  output logic [WIN_LOG2:0]   count,
  output logic                fill,
  output logic                alarm
);

  localparam int unsigned DEPTH = 1 << WIN_LOG2;
  localparam int unsigned SW    = 8 + WIN_LOG2;
  localparam logic [WIN_LOG2:0] CNT_FULL = {1'b1, {WIN_LOG2{1'b0}}};

  // Parameter legality checks at elaboration.
  if (WIN_LOG2 < 1 || WIN_LOG2 > 4) begin : g_bad_win
    $error("mag_window_stats: WIN_LOG2 must be 1..4");
  end
  if (THRESH_LO >= THRESH_HI) begin : g_bad_thresh
    $error("mag_window_stats: THRESH_LO must be below THRESH_HI");
  end

  logic [7:0]          win_q [DEPTH];
  logic [7:0]          win_d [DEPTH];
  logic [WIN_LOG2-1:0] ptr_q, ptr_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [WIN_LOG2:0]   cnt_q, cnt_d;
  logic [7:0]          last_q, last_d;
  logic [7:0]          max_q, max_d;
  logic [7:0]          min_q, min_d;
  logic [7:0]          stat_q, stat_d;
  logic [7:0]          avg;

  // Average is a plain shift of the running sum; biased low while filling.
  assign avg = 8'(sum_q >> WIN_LOG2);

  // Next-state for window, running sum and since-clear statistics.
  always_comb begin
    win_d  = win_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    max_d  = max_q;
    min_d  = min_q;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_d[i] = '0;
      ptr_d  = '0;
      sum_d  = '0;
      cnt_d  = '0;
      last_d = '0;
      max_d  = '0;
      min_d  = '1;
    end else if (mag_valid) begin
      // Oldest entry is zero until overwritten, so the sum stays exact.
      sum_d        = sum_q + SW'(mag_in) - SW'(win_q[ptr_q]);
      win_d[ptr_q] = mag_in;
      ptr_d        = ptr_q + WIN_LOG2'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + (WIN_LOG2+1)'(1);
      last_d = mag_in;
      if (mag_in > max_q) max_d = mag_in;
      if (mag_in < min_q) min_d = mag_in;
    end
  end

  // Output select, registered from the current state each cycle.
  always_comb begin
    stat_d = '0;
    case (sel)
      2'b00:   stat_d = last_q;
      2'b01:   stat_d = max_q;
      2'b10:   stat_d = min_q;
      default: stat_d = avg;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      max_q  <= '0;
      min_q  <= '1;
      stat_q <= '0;
    end else begin
      win_q  <= win_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      max_q  <= max_d;
      min_q  <= min_d;
      stat_q <= stat_d;
    end
  end

  assign stat_out = stat_q;
  assign count    = cnt_q;
  assign fill     = (cnt_q == CNT_FULL);

`ifdef MAG_ALARM_EN
  logic alarm_q, alarm_d;

  // Hysteresis on the average of the registered state; clear forces low.
  always_comb begin
    alarm_d = alarm_q;
    if (clear)                alarm_d = 1'b0;
    else if (avg >= THRESH_HI) alarm_d = 1'b1;
    else if (avg <= THRESH_LO) alarm_d = 1'b0;
  end

  // Alarm register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench for mag_window_stats (WIN_LOG2=3, default thresholds).
// A queue-based model of the window is compared on every falling edge,
// and directed literal expectations pin the model's values.
module tb_mag_window_stats;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mag_in = '0;
  logic       mag_valid = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] sel = 2'b10;
  logic [7:0] stat_out;
  logic [3:0] count;
  logic       fill;
  logic       alarm;

  int passed = 0;
  int total  = 0;
  bit done   = 1'b0;

  mag_window_stats #(
    .WIN_LOG2 (3),
    .THRESH_HI(8'd200),
    .THRESH_LO(8'd150)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mag_in   (mag_in),
    .mag_valid(mag_valid),
    .clear    (clear),
    .sel      (sel),
    .stat_out (stat_out),
    .count    (count),
    .fill     (fill),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int win[$];
  int m_last = 0, m_max = 0, m_min = 255;
  int e_stat = 0, e_alarm = 0;

  function automatic int m_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / DEPTH;
  endfunction

  initial forever begin
    int a;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      win.delete();
      m_last = 0; m_max = 0; m_min = 255;
      e_stat = 0; e_alarm = 0;
    end else begin
      a = m_avg();
      case (sel)
        2'b00:   e_stat = m_last;
        2'b01:   e_stat = m_max;
        2'b10:   e_stat = m_min;
        default: e_stat = a;
      endcase
`ifdef MAG_ALARM_EN
      if (clear)          e_alarm = 0;
      else if (a >= 200)  e_alarm = 1;
      else if (a <= 150)  e_alarm = 0;
`else
      e_alarm = 0;
`endif
      if (clear) begin
        win.delete();
        m_last = 0; m_max = 0; m_min = 255;
      end else if (mag_valid) begin
        win.push_back(int'(mag_in));
        if (win.size() > DEPTH) void'(win.pop_front());
        m_last = mag_in;
        if (mag_in > m_max) m_max = mag_in;
        if (mag_in < m_min) m_min = mag_in;
      end
    end
  end

  // ---------------- continuous compare ----------------
  initial forever begin
    @(negedge clk);
    if (!done) begin
      chk("stat_out", int'(stat_out), e_stat);
      chk("count", int'(count), win.size());
      chk("fill", int'(fill), int'(win.size() == DEPTH));
      chk("alarm", int'(alarm), e_alarm);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int v);
    mag_in = 8'(v); mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
  endtask

  task automatic show(input logic [1:0] s, input string name, input int exp);
    sel = s;
    @(negedge clk);
    chk(name, int'(stat_out), exp);
  endtask

  int exp_alarm_hi;

  initial begin
`ifdef MAG_ALARM_EN
    exp_alarm_hi = 1;
`else
    exp_alarm_hi = 0;
`endif
    // Reset held, then released.
    repeat (2) @(negedge clk);
    chk("rst_stat", int'(stat_out), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_alarm", int'(alarm), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("min_after_release", int'(stat_out), 255);

    // Fill the window with 10..80.
    for (int i = 1; i <= 8; i++) send(i * 10);
    chk("fill_count", int'(count), 8);
    chk("fill_flag", int'(fill), 1);
    show(2'b11, "avg_45", 45);
    show(2'b01, "max_80", 80);
    show(2'b10, "min_10", 10);
    show(2'b00, "last_80", 80);

    // One more sample displaces 10.
    sel = 2'b11;
    send(90);
    chk("count_sat", int'(count), 8);
    @(negedge clk);
    chk("avg_55", int'(stat_out), 55);
    show(2'b10, "min_still_10", 10);

    // Alarm hysteresis.
    sel = 2'b11;
    for (int i = 0; i < 8; i++) send(220);
    @(negedge clk);
    chk("alarm_set", int'(alarm), exp_alarm_hi);
    chk("avg_220", int'(stat_out), 220);
    for (int i = 0; i < 4; i++) send(100);
    @(negedge clk);
    chk("avg_160", int'(stat_out), 160);
    chk("alarm_held", int'(alarm), exp_alarm_hi);
    send(100);
    @(negedge clk);
    chk("avg_145", int'(stat_out), 145);
    chk("alarm_clr", int'(alarm), 0);

    // Clear beats a simultaneous sample.
    clear = 1'b1; mag_in = 8'd99; mag_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; mag_valid = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_fill", int'(fill), 0);
    chk("clr_alarm", int'(alarm), 0);
    show(2'b00, "clr_last", 0);
    show(2'b01, "clr_max", 0);
    show(2'b10, "clr_min", 255);
    show(2'b11, "clr_avg", 0);

    // Asynchronous reset in the middle of a stream.
    send(30);
    send(40);
    mag_in = 8'd60; mag_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_stat", int'(stat_out), 0);
    chk("async_count", int'(count), 0);
    chk("async_fill", int'(fill), 0);
    chk("async_alarm", int'(alarm), 0);
    mag_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 2'b11;
    send(50);
    chk("post_rst_count", int'(count), 1);
    @(negedge clk);
    chk("post_rst_avg", int'(stat_out), 6);

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
